uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single async transmitter between NUM_REQ byte producers, e.g. the PIA display path and a debug/monitor port.
- Each requester presents bytes with a valid/ready handshake.
- The block sequences the transmitter's start/busy protocol one byte at a time and flags a transmitter that never goes busy.
- It sits between the producers and the transmitter, in the same clock domain.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- BUSY_TIMEOUT, 16: cycles allowed in S_WAIT_BUSY for tx_busy to rise before aborting; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  per-requester accept strobe, one-hot or zero.
- tx_start  out  1  start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter, held stable from tx_start until the return to S_IDLE.
- tx_busy  in  1  transmitter busy.
- active  out  1  high while a byte is in flight (any state other than S_IDLE).
- grant_id  out  2  index of the requester owning the current or last byte.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (async assert, sync release):
  - state = S_IDLE.
  - tx_start = 0, tx_data = 0x00, active = 0, grant_id = 0, err_timeout = 0, req_ready = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Arbitration:
  - Combinational, evaluated only when state == S_IDLE and tx_busy == 0.
  - Winner g is the first i with req_valid[i] set, searching last+1, last+2, … modulo NUM_REQ.
  - req_ready[g] = 1 only in that condition; req_ready is 0 in every other state.
- Handshake:
  - Transfer occurs on req_valid[g] & req_ready[g].
  - Same edge: hold <= req_data[g], grant_id <= g, last <= g, state -> S_START.
  - Requesters must hold data while valid and not ready; req_valid may drop at any time before acceptance with no side effect.
- State S_START (1 cycle): tx_data <= hold, tx_start <= 1 (registered), state -> S_WAIT_BUSY. tx_start is high for exactly one cycle per byte.
- State S_WAIT_BUSY:
  - Counter cnt increments each cycle.
  - If tx_busy = 1: cnt <= 0, state -> S_WAIT_DONE.
  - Else if cnt == BUSY_TIMEOUT-1: err_timeout <= 1, cnt <= 0, state -> S_IDLE; the byte is dropped.
- State S_WAIT_DONE: when tx_busy = 0, state -> S_IDLE (or S_START for the CRLF case, see Optional Feature).
- Latency:
  - Handshake edge to tx_start high: 1 cycle.
  - Earliest next req_ready: the cycle after tx_busy falls.
- Fairness: a requester holding valid continuously cannot be granted twice in a row while another requester is valid.
- err_timeout: err_clr clears it. If a set and err_clr occur in the same cycle, set wins.
- tx_busy already high while in S_IDLE (foreign start or reset skew): no grant until it falls.
- active = (state != S_IDLE), registered.

Optional Feature:
- Macro UART_TX_SCHED_CRLF_EN.
- Defined: when a byte with (hold & 0x7F) == 0x0D completes in S_WAIT_DONE:
  - A pending flag sets, hold <= 0x0A, state -> S_START.
  - The LF is sent under the same grant_id before any re-arbitration; req_ready stays 0 meanwhile.
  - If the CR timed out in S_WAIT_BUSY, no LF is sent.
- Undefined: bytes pass unmodified; S_WAIT_DONE always returns to S_IDLE.

Decomposition:
- Package uart_pkg:
  - state enum: S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE.
  - ASCII_CR = 8'h0D, ASCII_LF = 8'h0A.
  - Localparam for the grant index width.
- Sub-module rr_arbiter: NUM_REQ request vector plus last pointer in, one-hot grant plus encoded index out; purely combinational.

Test Plan:
- Reset: drive rst_n=0 mid-byte (state S_WAIT_DONE) -> all outputs 0 immediately; after release, req_valid[0]=1 with 0x41 -> req_ready[0] pulses, tx_start one cycle later, tx_data=0x41.
- Contention: req 0 sends 0x31 and req 1 sends 0x32, both valid continuously; model transmitter busy 20 cycles per byte -> order 0x31, 0x32, 0x31, 0x32; grant_id alternates 0,1,0,1.
- Back-pressure: req_valid[1]=1 with 0x55 while a byte is in flight -> req_ready stays 0 until the cycle after tx_busy falls, then 0x55 is accepted.
- Timeout: tx_busy tied 0, send 0x7E -> err_timeout=1 after BUSY_TIMEOUT cycles in S_WAIT_BUSY, state returns to S_IDLE; err_clr pulse -> err_timeout=0.
- CRLF (macro defined): req 0 sends 0x8D while req 1 is valid -> transmitter sees 0x8D, then 0x0A with grant_id=0, then the req 1 byte; macro undefined -> 0x8D only, then the req 1 byte.
- Stability: during any in-flight byte, tx_data is unchanged and tx_start was asserted exactly once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } stateT;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Grant index width covers the full 2..4 requester range.
   localparam int unsigned GNT_W = 2;

   function automatic logic isCr(input logic [7:0] b);
      return (b & 8'h7F) == ASCII_CR;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GNT_W-1:0]   last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [GNT_W-1:0]   gntIdx
);

   logic found;

   always_comb begin
      gnt    = '0;
      gntIdx = '0;
      found  = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i == ((32'(last) + k) % NUM_REQ))) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               gntIdx = GNT_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one async transmitter between byte producers.
// Optional CR->CRLF expansion is enabled with `define UART_TX_SCHED_CRLF_EN.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 active,
   output logic [GNT_W-1:0]     grant_id,
   output logic                 err_timeout,
   input  logic                 err_clr
);

   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

   stateT              state, nextState;
   logic [7:0]         holdByte, nextHold, selData, nextTxData;
   logic [CNT_W-1:0]   cnt, nextCnt;
   logic [GNT_W-1:0]   lastPtr, nextLast, winIdx, nextGrant;
   logic [NUM_REQ-1:0] winGnt;
   logic               canArb, accept, nextStart, nextErr;
`ifdef UART_TX_SCHED_CRLF_EN
   logic               pending, nextPending;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .req    (req_valid),
      .last   (lastPtr),
      .gnt    (winGnt),
      .gntIdx (winIdx)
   );

   // Ready is only offered while idle with the transmitter quiet, and never in reset.
   assign canArb    = rst_n && (state == S_IDLE) && !tx_busy;
   assign req_ready = canArb ? winGnt : '0;
   assign accept    = |req_ready;

   always_comb begin
      selData = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winGnt[i]) selData = req_data[8*i +: 8];
      end
   end

   always_comb begin
      nextState  = state;
      nextHold   = holdByte;
      nextCnt    = cnt;
      nextLast   = lastPtr;
      nextGrant  = grant_id;
      nextStart  = 1'b0;
      nextTxData = tx_data;
      nextErr    = err_timeout;
`ifdef UART_TX_SCHED_CRLF_EN
      nextPending = pending;
`endif
      if (err_clr) nextErr = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               nextHold  = selData;
               nextGrant = winIdx;
               nextLast  = winIdx;
               nextState = S_START;
            end
         end
         S_START: begin
            nextTxData = holdByte;
            nextStart  = 1'b1;
            nextState  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               nextCnt   = '0;
               nextState = S_WAIT_DONE;
            end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               nextErr   = 1'b1;
               nextCnt   = '0;
               nextState = S_IDLE;
            end else begin
               nextCnt = cnt + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
`ifdef UART_TX_SCHED_CRLF_EN
               // A completed CR is followed by an LF under the same grant.
               if (!pending && isCr(holdByte)) begin
                  nextPending = 1'b1;
                  nextHold    = ASCII_LF;
                  nextState   = S_START;
               end else begin
                  nextState = S_IDLE;
               end
`else
               nextState = S_IDLE;
`endif
            end
         end
         default: nextState = S_IDLE;
      endcase

`ifdef UART_TX_SCHED_CRLF_EN
      if (nextState == S_IDLE) nextPending = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         holdByte    <= '0;
         cnt         <= '0;
         lastPtr     <= GNT_W'(NUM_REQ - 1);
         grant_id    <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         active      <= 1'b0;
         err_timeout <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
         pending     <= 1'b0;
`endif
      end else begin
         state       <= nextState;
         holdByte    <= nextHold;
         cnt         <= nextCnt;
         lastPtr     <= nextLast;
         grant_id    <= nextGrant;
         tx_start    <= nextStart;
         tx_data     <= nextTxData;
         active      <= (nextState != S_IDLE);
         err_timeout <= nextErr;
`ifdef UART_TX_SCHED_CRLF_EN
         pending     <= nextPending;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a simple transmitter model.
module tb_uart_tx_sched;

   localparam int unsigned NR = 2;
   localparam int unsigned BT = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic            tx_busy;
   logic            active;
   logic [1:0]      grant_id;
   logic            err_timeout;
   logic            err_clr;

   int checks = 0;
   int errors = 0;

   bit         txMode;
   int         busyLen;
   int         busyCnt;
   logic [7:0] txLog[$];
   logic [1:0] gidLog[$];

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .active      (active),
      .grant_id    (grant_id),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   // Transmitter model: logs each start, then stays busy busyLen cycles when enabled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy <= 1'b0;
         busyCnt <= 0;
      end else if (tx_start) begin
         txLog.push_back(tx_data);
         gidLog.push_back(grant_id);
         if (txMode) begin
            tx_busy <= 1'b1;
            busyCnt <= busyLen;
         end
      end else if (tx_busy) begin
         if (busyCnt <= 1) tx_busy <= 1'b0;
         busyCnt <= busyCnt - 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic doReset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      err_clr   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txLog.delete();
      gidLog.delete();
      @(negedge clk);
   endtask

   task automatic sendByte(input int r, input logic [7:0] d, output bit ok);
      req_data[8*r +: 8] = d;
      req_valid[r]       = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         #1;
         if (req_ready[r]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic waitIdle(input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (!active && !tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      rst_n = 1'b0; req_valid = '0; req_data = '0; err_clr = 1'b0;
      txMode = 1'b1; busyLen = 20;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_start, tx_data, active, grant_id, err_timeout, req_ready} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {tx_start, tx_data, active, grant_id, err_timeout, req_ready});
      end
      rst_n = 1'b1;
      req_data[7:0] = 8'h41;
      req_valid[0] = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL first_ready got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({active, tx_start} !== 2'b10) begin
         errors++; $display("FAIL accept_cycle got act/start %b want 10", {active, tx_start});
      end
      @(negedge clk);
      checks++;
      if ({tx_start, tx_data, grant_id} !== {1'b1, 8'h41, 2'd0}) begin
         errors++; $display("FAIL start_latency got %b/%h/%0d want 1/41/0", tx_start, tx_data, grant_id);
      end
      ok = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (tx_busy) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL busy_seen got 0 want 1"); end
      repeat (3) @(negedge clk);
      req_valid[0] = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_start, tx_data, active, grant_id, err_timeout, req_ready} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset got %h want 0",
                  {tx_start, tx_data, active, grant_id, err_timeout, req_ready});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txLog.delete(); gidLog.delete();
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL ready_after_reset got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_start, tx_data} !== {1'b1, 8'h41}) begin
         errors++; $display("FAIL restart_byte got %b/%h want 1/41", tx_start, tx_data);
      end
      waitIdle(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_idle got busy want idle"); end
   endtask

   task automatic test_contention();
      bit ok;
      logic [7:0] expD[4] = '{8'h31, 8'h32, 8'h31, 8'h32};
      logic [1:0] expG[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
      doReset();
      txMode = 1'b1; busyLen = 20;
      req_data  = {8'h32, 8'h31};
      req_valid = 2'b11;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (txLog.size() >= 4) begin ok = 1'b1; break; end
      end
      req_valid = '0;
      checks++;
      if (!ok) begin errors++; $display("FAIL contention_timeout got %0d bytes want 4", txLog.size()); end
      waitIdle(100, ok);
      checks++;
      if (txLog.size() !== 4) begin errors++; $display("FAIL contention_count got %0d want 4", txLog.size()); end
      for (int i = 0; i < 4 && i < txLog.size(); i++) begin
         checks++;
         if ({txLog[i], gidLog[i]} !== {expD[i], expG[i]}) begin
            errors++;
            $display("FAIL contention_order[%0d] got %h/%0d want %h/%0d", i, txLog[i], gidLog[i], expD[i], expG[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit seenBusy;
      int fallIdx, readyIdx;
      doReset();
      txMode = 1'b1; busyLen = 20;
      sendByte(0, 8'hA5, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_first_accept got 0 want 1"); end
      req_data[15:8] = 8'h55;
      req_valid[1]   = 1'b1;
      seenBusy = 1'b0; fallIdx = -1; readyIdx = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (tx_busy) seenBusy = 1'b1;
         if (seenBusy && !tx_busy && fallIdx < 0) fallIdx = n;
         if (req_ready[1]) begin readyIdx = n; break; end
      end
      @(posedge clk); #1; req_valid[1] = 1'b0;
      checks++;
      if (fallIdx < 0 || readyIdx !== fallIdx + 1) begin
         errors++; $display("FAIL bp_ready_timing got ready@%0d want busy_fall@%0d+1", readyIdx, fallIdx);
      end
      waitIdle(100, ok);
      checks++;
      if (txLog.size() !== 2) begin
         errors++; $display("FAIL bp_count got %0d want 2", txLog.size());
      end else begin
         checks++;
         if ({txLog[0], gidLog[0], txLog[1], gidLog[1]} !== {8'hA5, 2'd0, 8'h55, 2'd1}) begin
            errors++;
            $display("FAIL bp_bytes got %h/%0d %h/%0d want a5/0 55/1", txLog[0], gidLog[0], txLog[1], gidLog[1]);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int k;
      doReset();
      txMode = 1'b0;
      sendByte(0, 8'h7E, ok);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", tx_start); end
      k = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (err_timeout) begin k = n; break; end
      end
      checks++;
      if (k !== int'(BT)) begin errors++; $display("FAIL to_cycles got %0d want %0d", k, BT); end
      checks++;
      if ({active, txLog.size() == 1} !== 2'b01) begin
         errors++; $display("FAIL to_idle got active %b starts %0d want 0/1", active, txLog.size());
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err_timeout); end
      err_clr = 1'b1;
      sendByte(0, 8'h7E, ok);
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (err_timeout) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL set_wins got 0 want 1"); end
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL err_clr_held got %b want 0", err_timeout); end
   endtask

   task automatic test_crlf();
      bit ok;
      doReset();
      txMode = 1'b1; busyLen = 5;
      req_data  = {8'h42, 8'h8D};
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL crlf_first got %b want 01", req_ready); end
      @(posedge clk); #1; req_valid[0] = 1'b0;
      sendByte(1, 8'h42, ok);
      waitIdle(100, ok);
`ifdef UART_TX_SCHED_CRLF_EN
      checks++;
      if (txLog.size() !== 3) begin
         errors++; $display("FAIL crlf_count got %0d want 3", txLog.size());
      end else begin
         checks++;
         if ({txLog[0], gidLog[0], txLog[1], gidLog[1], txLog[2], gidLog[2]}
             !== {8'h8D, 2'd0, 8'h0A, 2'd0, 8'h42, 2'd1}) begin
            errors++;
            $display("FAIL crlf_seq got %h/%0d %h/%0d %h/%0d want 8d/0 0a/0 42/1",
                     txLog[0], gidLog[0], txLog[1], gidLog[1], txLog[2], gidLog[2]);
         end
      end
`else
      checks++;
      if (txLog.size() !== 2) begin
         errors++; $display("FAIL crlf_count got %0d want 2", txLog.size());
      end else begin
         checks++;
         if ({txLog[0], gidLog[0], txLog[1], gidLog[1]} !== {8'h8D, 2'd0, 8'h42, 2'd1}) begin
            errors++;
            $display("FAIL crlf_seq got %h/%0d %h/%0d want 8d/0 42/1", txLog[0], gidLog[0], txLog[1], gidLog[1]);
         end
      end
`endif
   endtask

   task automatic test_stability();
      bit ok;
      int starts, changes;
      logic [7:0] seen;
      doReset();
      txMode = 1'b1; busyLen = 8;
      sendByte(0, 8'h3C, ok);
      starts = 0; changes = 0; seen = 8'h00; ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (tx_start) begin starts++; seen = tx_data; end
         else if (starts > 0 && tx_data !== seen) changes++;
         if (!active && !tx_busy) begin ok = 1'b1; break; end
      end
      checks++;
      if (starts !== 1) begin errors++; $display("FAIL start_pulses got %0d want 1", starts); end
      checks++;
      if ({changes, seen} !== {32'd0, 8'h3C}) begin
         errors++; $display("FAIL tx_data_stable got %0d changes byte %h want 0/3c", changes, seen);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stab_idle got busy want idle"); end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_back_to_back();
      test_timeout();
      test_crlf();
      test_stability();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
